// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, handshakes with instruction memory and
// feeds the IF/ID register, honouring stall, flush and branch/jump redirect.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_data_i,
  input  logic        imem_ready_i,
  output logic [31:0] ifid_pc_o,
  output logic [31:0] ifid_pc4_o,
  output logic [31:0] ifid_inst_o,
  output logic        ifid_valid_o
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t            state;
  logic [XLEN-1:0]   pc;
  logic [XLEN-1:0]   pc_plus4;
  logic [XLEN-1:0]   redirect_tgt;
  logic              pend_valid;
  logic [XLEN-1:0]   pend_pc;
  logic [XLEN-1:0]   hold_buf;

  assign pc_plus4     = pc + XLEN'(4);
  assign redirect_tgt = {redirect_pc_i[XLEN-1:2], 2'b00};
  assign imem_addr_o  = pc;

  // PC only moves on a completed fetch, so the address is stable while req waits on ready.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= IDLE;
      pc           <= RESET_PC;
      imem_req_o   <= 1'b0;
      pend_valid   <= 1'b0;
      pend_pc      <= '0;
      hold_buf     <= '0;
      ifid_pc_o    <= '0;
      ifid_pc4_o   <= '0;
      ifid_inst_o  <= NOP_INST;
      ifid_valid_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            state      <= FETCH;
            imem_req_o <= 1'b1;
          end
        end

        FETCH: begin
          if (redirect_i) begin
            ifid_inst_o  <= NOP_INST;
            ifid_valid_o <= 1'b0;
            if (imem_ready_i) begin
              pc         <= redirect_tgt;
              pend_valid <= 1'b0;
            end else begin
              pend_valid <= 1'b1;
              pend_pc    <= redirect_tgt;
            end
          end else if (pend_valid) begin
            // Outstanding fetch belongs to the wrong path; drop it when it lands.
            ifid_inst_o  <= NOP_INST;
            ifid_valid_o <= 1'b0;
            if (imem_ready_i) begin
              pc         <= pend_pc;
              pend_valid <= 1'b0;
            end
          end else if (flush_i) begin
            ifid_inst_o  <= NOP_INST;
            ifid_valid_o <= 1'b0;
          end else if (imem_ready_i && stall_i) begin
            hold_buf   <= imem_data_i;
            state      <= HOLD;
            imem_req_o <= 1'b0;
          end else if (imem_ready_i) begin
            ifid_pc_o    <= pc;
            ifid_pc4_o   <= pc_plus4;
            ifid_inst_o  <= imem_data_i;
            ifid_valid_o <= 1'b1;
            pc           <= pc_plus4;
          end else if (!stall_i) begin
            ifid_inst_o  <= NOP_INST;
            ifid_valid_o <= 1'b0;
          end
        end

        HOLD: begin
          if (redirect_i) begin
            pc           <= redirect_tgt;
            ifid_inst_o  <= NOP_INST;
            ifid_valid_o <= 1'b0;
            state        <= FETCH;
            imem_req_o   <= 1'b1;
          end else if (flush_i) begin
            ifid_inst_o  <= NOP_INST;
            ifid_valid_o <= 1'b0;
            state        <= FETCH;
            imem_req_o   <= 1'b1;
          end else if (!stall_i) begin
            ifid_pc_o    <= pc;
            ifid_pc4_o   <= pc_plus4;
            ifid_inst_o  <= hold_buf;
            ifid_valid_o <= 1'b1;
            pc           <= pc_plus4;
            state        <= FETCH;
            imem_req_o   <= 1'b1;
          end
        end

        default: begin
          state      <= IDLE;
          imem_req_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; memory returns the request address as the
// instruction word and a poison value whenever no request is outstanding.
module tb_fetch_stage;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic        stall_i;
  logic        flush_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_data_i;
  logic        imem_ready_i;
  logic [31:0] ifid_pc_o;
  logic [31:0] ifid_pc4_o;
  logic [31:0] ifid_inst_o;
  logic        ifid_valid_o;

  int checks = 0;
  int errors = 0;

  fetch_stage dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .stall_i      (stall_i),
    .flush_i      (flush_i),
    .redirect_i   (redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_data_i  (imem_data_i),
    .imem_ready_i (imem_ready_i),
    .ifid_pc_o    (ifid_pc_o),
    .ifid_pc4_o   (ifid_pc4_o),
    .ifid_inst_o  (ifid_inst_o),
    .ifid_valid_o (ifid_valid_o)
  );

  always #5 clk_i = ~clk_i;

  assign imem_data_i = imem_req_o ? imem_addr_o : 32'hDEAD_BEEF;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; start_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
    redirect_i = 1'b0; redirect_pc_i = '0; imem_ready_i = 1'b1;
    #3;
    checks++;
    if ({imem_req_o, imem_addr_o} !== {1'b0, 32'h0}) begin
      errors++; $display("FAIL reset_req_addr: got %h expected %h", {imem_req_o, imem_addr_o}, {1'b0, 32'h0});
    end
    checks++;
    if ({ifid_pc_o, ifid_pc4_o, ifid_inst_o, ifid_valid_o} !== {32'h0, 32'h0, 32'h0, 1'b0}) begin
      errors++; $display("FAIL reset_ifid: got %h %h %h %b", ifid_pc_o, ifid_pc4_o, ifid_inst_o, ifid_valid_o);
    end
    tick();
    rst_i = 1'b0;
    tick();
    checks++;
    if (imem_req_o !== 1'b0) begin
      errors++; $display("FAIL idle_no_req: got %b expected 0", imem_req_o);
    end
  endtask

  task automatic test_stream();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    checks++;
    if ({imem_req_o, imem_addr_o, ifid_valid_o} !== {1'b1, 32'h0, 1'b0}) begin
      errors++; $display("FAIL start_latency: got req=%b addr=%h valid=%b", imem_req_o, imem_addr_o, ifid_valid_o);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({ifid_pc_o, ifid_pc4_o, ifid_inst_o, ifid_valid_o, imem_addr_o} !==
          {32'(4*i), 32'(4*i+4), 32'(4*i), 1'b1, 32'(4*i+4)}) begin
        errors++; $display("FAIL stream_%0d: got pc=%h pc4=%h inst=%h v=%b addr=%h", i,
                           ifid_pc_o, ifid_pc4_o, ifid_inst_o, ifid_valid_o, imem_addr_o);
      end
    end
  endtask

  task automatic test_ready_low();
    imem_ready_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({imem_req_o, imem_addr_o, ifid_pc_o, ifid_inst_o, ifid_valid_o} !==
          {1'b1, 32'h10, 32'hC, 32'h0, 1'b0}) begin
        errors++; $display("FAIL wait_bubble_%0d: got req=%b addr=%h pc=%h inst=%h v=%b", i,
                           imem_req_o, imem_addr_o, ifid_pc_o, ifid_inst_o, ifid_valid_o);
      end
    end
    imem_ready_i = 1'b1;
    tick();
    checks++;
    if ({ifid_pc_o, ifid_pc4_o, ifid_inst_o, ifid_valid_o, imem_addr_o} !==
        {32'h10, 32'h14, 32'h10, 1'b1, 32'h14}) begin
      errors++; $display("FAIL wait_complete: got pc=%h pc4=%h inst=%h v=%b addr=%h",
                         ifid_pc_o, ifid_pc4_o, ifid_inst_o, ifid_valid_o, imem_addr_o);
    end
  endtask

  task automatic test_redirect_ready();
    redirect_i = 1'b1; redirect_pc_i = 32'h23;
    tick();
    redirect_i = 1'b0;
    checks++;
    if ({imem_addr_o, ifid_pc_o, ifid_inst_o, ifid_valid_o} !== {32'h20, 32'h10, 32'h0, 1'b0}) begin
      errors++; $display("FAIL redirect_ready: got addr=%h pc=%h inst=%h v=%b",
                         imem_addr_o, ifid_pc_o, ifid_inst_o, ifid_valid_o);
    end
  endtask

  task automatic test_stall();
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({imem_req_o, imem_addr_o, ifid_pc_o, ifid_valid_o} !== {1'b0, 32'h20, 32'h10, 1'b0}) begin
        errors++; $display("FAIL stall_hold_%0d: got req=%b addr=%h pc=%h v=%b", i,
                           imem_req_o, imem_addr_o, ifid_pc_o, ifid_valid_o);
      end
    end
    stall_i = 1'b0;
    tick();
    checks++;
    if ({imem_req_o, ifid_pc_o, ifid_pc4_o, ifid_inst_o, ifid_valid_o, imem_addr_o} !==
        {1'b1, 32'h20, 32'h24, 32'h20, 1'b1, 32'h24}) begin
      errors++; $display("FAIL stall_release: got req=%b pc=%h pc4=%h inst=%h v=%b addr=%h",
                         imem_req_o, ifid_pc_o, ifid_pc4_o, ifid_inst_o, ifid_valid_o, imem_addr_o);
    end
    tick();
    checks++;
    if ({ifid_pc_o, ifid_inst_o, ifid_valid_o, imem_addr_o} !== {32'h24, 32'h24, 1'b1, 32'h28}) begin
      errors++; $display("FAIL stall_next: got pc=%h inst=%h v=%b addr=%h",
                         ifid_pc_o, ifid_inst_o, ifid_valid_o, imem_addr_o);
    end
  endtask

  task automatic test_redirect_pending();
    redirect_i = 1'b1; redirect_pc_i = 32'h30;
    tick();
    imem_ready_i = 1'b0; redirect_pc_i = 32'h100;
    tick();
    redirect_i = 1'b0;
    checks++;
    if ({imem_req_o, imem_addr_o, ifid_valid_o} !== {1'b1, 32'h30, 1'b0}) begin
      errors++; $display("FAIL pend_latch: got req=%b addr=%h v=%b", imem_req_o, imem_addr_o, ifid_valid_o);
    end
    tick();
    checks++;
    if ({imem_addr_o, ifid_valid_o} !== {32'h30, 1'b0}) begin
      errors++; $display("FAIL pend_wait: got addr=%h v=%b", imem_addr_o, ifid_valid_o);
    end
    imem_ready_i = 1'b1;
    tick();
    checks++;
    if ({imem_addr_o, ifid_inst_o, ifid_valid_o} !== {32'h100, 32'h0, 1'b0}) begin
      errors++; $display("FAIL pend_drop: got addr=%h inst=%h v=%b", imem_addr_o, ifid_inst_o, ifid_valid_o);
    end
    tick();
    checks++;
    if ({ifid_pc_o, ifid_pc4_o, ifid_inst_o, ifid_valid_o, imem_addr_o} !==
        {32'h100, 32'h104, 32'h100, 1'b1, 32'h104}) begin
      errors++; $display("FAIL pend_target: got pc=%h pc4=%h inst=%h v=%b addr=%h",
                         ifid_pc_o, ifid_pc4_o, ifid_inst_o, ifid_valid_o, imem_addr_o);
    end
  endtask

  task automatic test_flush_stall();
    redirect_i = 1'b1; redirect_pc_i = 32'h40;
    tick();
    redirect_i = 1'b0; flush_i = 1'b1; stall_i = 1'b1;
    tick();
    flush_i = 1'b0; stall_i = 1'b0;
    checks++;
    if ({imem_req_o, imem_addr_o, ifid_pc_o, ifid_inst_o, ifid_valid_o} !==
        {1'b1, 32'h40, 32'h100, 32'h0, 1'b0}) begin
      errors++; $display("FAIL flush_stall: got req=%b addr=%h pc=%h inst=%h v=%b",
                         imem_req_o, imem_addr_o, ifid_pc_o, ifid_inst_o, ifid_valid_o);
    end
    tick();
    checks++;
    if ({ifid_pc_o, ifid_pc4_o, ifid_inst_o, ifid_valid_o} !== {32'h40, 32'h44, 32'h40, 1'b1}) begin
      errors++; $display("FAIL flush_refetch: got pc=%h pc4=%h inst=%h v=%b",
                         ifid_pc_o, ifid_pc4_o, ifid_inst_o, ifid_valid_o);
    end
  endtask

  task automatic test_wrap();
    redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFF;
    tick();
    redirect_i = 1'b0;
    tick();
    checks++;
    if ({ifid_pc_o, ifid_pc4_o, ifid_inst_o, ifid_valid_o, imem_addr_o} !==
        {32'hFFFF_FFFC, 32'h0, 32'hFFFF_FFFC, 1'b1, 32'h0}) begin
      errors++; $display("FAIL pc_wrap: got pc=%h pc4=%h inst=%h v=%b addr=%h",
                         ifid_pc_o, ifid_pc4_o, ifid_inst_o, ifid_valid_o, imem_addr_o);
    end
  endtask

  task automatic test_reset_mid_hold();
    stall_i = 1'b1;
    tick();
    checks++;
    if (imem_req_o !== 1'b0) begin
      errors++; $display("FAIL hold_entry: got req=%b expected 0", imem_req_o);
    end
    #2 rst_i = 1'b1;
    #1;
    checks++;
    if ({imem_req_o, imem_addr_o, ifid_pc_o, ifid_pc4_o, ifid_inst_o, ifid_valid_o} !==
        {1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0}) begin
      errors++; $display("FAIL async_reset: got req=%b addr=%h pc=%h pc4=%h inst=%h v=%b",
                         imem_req_o, imem_addr_o, ifid_pc_o, ifid_pc4_o, ifid_inst_o, ifid_valid_o);
    end
    tick();
    rst_i = 1'b0; stall_i = 1'b0;
    tick();
    checks++;
    if ({imem_req_o, ifid_valid_o} !== {1'b0, 1'b0}) begin
      errors++; $display("FAIL post_reset_idle: got req=%b v=%b", imem_req_o, ifid_valid_o);
    end
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    checks++;
    if ({imem_req_o, imem_addr_o} !== {1'b1, 32'h0}) begin
      errors++; $display("FAIL restart: got req=%b addr=%h", imem_req_o, imem_addr_o);
    end
    tick();
    checks++;
    if ({ifid_pc_o, ifid_pc4_o, ifid_inst_o, ifid_valid_o} !== {32'h0, 32'h4, 32'h0, 1'b1}) begin
      errors++; $display("FAIL restart_first: got pc=%h pc4=%h inst=%h v=%b",
                         ifid_pc_o, ifid_pc4_o, ifid_inst_o, ifid_valid_o);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_ready_low();
    test_redirect_ready();
    test_stall();
    test_redirect_pending();
    test_flush_stall();
    test_wrap();
    test_reset_mid_hold();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage for the pipelined MIPS CPU. It sits directly upstream of decode (Control, Registers, Sign_Extend, ALU_Control consume its IF/ID outputs) and replaces the free-running PC/Add_PC pair of the single-cycle core. It owns the PC, runs a req/ready handshake to instruction memory, and applies stall, flush and branch/jump redirect. It drives the IF/ID pipeline register.

## Interface
- RESET_PC, 32'h0000_0000, PC value after reset and while idle
- NOP_INST, 32'h0000_0000, instruction word inserted as a bubble (sll $0,$0,0)

- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  reset; asynchronous, active-high
- start_i  in  1  begin fetching; sampled only in IDLE
- stall_i  in  1  hazard unit: hold PC and IF/ID
- flush_i  in  1  force bubble into IF/ID
- redirect_i  in  1  taken branch/jump from decode
- redirect_pc_i  in  32  redirect target
- imem_req_o  out  1  fetch request valid
- imem_addr_o  out  32  fetch address; equals PC
- imem_data_i  in  32  instruction word, valid when imem_ready_i=1
- imem_ready_i  in  1  memory returns data this cycle
- ifid_pc_o  out  32  PC of instruction in IF/ID
- ifid_pc4_o  out  32  ifid_pc_o + 4
- ifid_inst_o  out  32  instruction in IF/ID
- ifid_valid_o  out  1  IF/ID holds a real instruction

## Operation
- A fetch completes in a cycle with imem_req_o=1 and imem_ready_i=1. While imem_req_o=1 and ready is low, imem_addr_o must stay constant.
- State machine:
  - IDLE: req=0, PC=RESET_PC. start_i=1 -> FETCH.
  - FETCH: req=1.
  - HOLD: req=0. A fetched word is parked in the 32-bit hold buffer.
- FETCH, resolved per cycle in priority order:
  - redirect_i with ready=1: drop the data; PC<=redirect_pc_i; IF/ID<=bubble.
  - redirect_i with ready=0: latch the target into a pending-redirect register; IF/ID<=bubble; PC unchanged. When ready arrives, drop that data and load PC from the pending target.
  - flush_i: IF/ID<=bubble. Any word arriving this cycle is dropped; PC not advanced, so the same address is refetched.
  - ready=1 with stall_i: park the word in the hold buffer -> HOLD; PC and IF/ID hold.
  - ready=1 otherwise: IF/ID<={PC, PC+4, data, valid=1}; PC<=PC+4.
  - ready=0: IF/ID<=bubble unless stall_i (hold).
- HOLD, priority order:
  - redirect_i: discard the buffer; PC<=redirect_pc_i; IF/ID<=bubble -> FETCH.
  - flush_i: IF/ID<=bubble; discard the buffer -> FETCH at the same PC.
  - stall_i: stay in HOLD.
  - otherwise: IF/ID<=buffer word with PC/PC+4, valid=1; PC<=PC+4 -> FETCH.
- Bubble means ifid_inst_o=NOP_INST, ifid_valid_o=0. ifid_pc_o/ifid_pc4_o hold their previous values.
- Width rules: PC+4 is 32-bit modulo 2^32, so 32'hFFFF_FFFC wraps to 0. Bits [1:0] of redirect_pc_i are forced to 0.
- start_i is ignored outside IDLE. Only reset returns the block to IDLE.

## Timing
- Reset values, applied immediately on rst_i=1:
  - state IDLE, PC=RESET_PC
  - imem_req_o=0, imem_addr_o=RESET_PC
  - ifid_pc_o=0, ifid_pc4_o=0, ifid_inst_o=NOP_INST, ifid_valid_o=0
  - pending-redirect clear, hold buffer 0
- Reset mid-handshake abandons the request with no further outputs. Memory must tolerate req dropping.
- Latency: start_i sampled at edge N -> req=1 after N. With ready tied high, first IF/ID valid after edge N+1, then one instruction per cycle.
- Redirect: target appears on imem_addr_o one cycle after redirect_i (ready=0 case: one cycle after the pending fetch completes). Exactly one bubble enters IF/ID in the ready-tied-high case.
- Stall: takes effect at the same edge; IF/ID and PC are unchanged across every stalled edge.
- Simultaneous stall+flush: flush wins for IF/ID, PC holds. Simultaneous stall+redirect: redirect wins.

## Test plan
- Reset then start, ready=1, memory word=address: IF/ID shows (0,4,0x0),(4,8,0x4),(8,C,0x8) on consecutive cycles, valid=1.
- Ready low 2 cycles per fetch at PC=0x10: addr held 0x10, two bubbles, then IF/ID=(0x10,0x14,word) and addr 0x14.
- stall_i for 3 cycles as word for 0x20 returns: IF/ID frozen, req=0 in HOLD; after release IF/ID=(0x20,…), next addr 0x24, no word lost or duplicated.
- redirect_i to 0x100 while fetch of 0x30 is waiting on ready: addr stays 0x30 until ready, data dropped, next addr 0x100, no valid 0x30 in IF/ID.
- flush_i and stall_i together at PC=0x40: IF/ID=NOP, valid=0, 0x40 refetched.
- rst_i asserted mid-HOLD: outputs at reset values immediately; start_i restarts fetch at RESET_PC.
